// File: rtl/scan_chain_driver.sv
// Master-side driver for a two-phase scan chain: generates SClkP/SClkN, SEnable, SUpdate, SIn
// and collects SOut into RdData. Optional abort support is enabled by SCAN_DRIVER_ABORT_EN.
module scan_chain_driver #(
   parameter int CHAIN_LENGTH = 87,
   parameter int CLK_DIV      = 2
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic                    Start,
   input  logic                    CaptureEn,
   input  logic                    UpdateEn,
   input  logic [CHAIN_LENGTH-1:0] WrData,
   output logic [CHAIN_LENGTH-1:0] RdData,
   output logic                    Busy,
   output logic                    Done,
   output logic                    SClkP,
   output logic                    SClkN,
   output logic                    SReset,
   output logic                    SEnable,
   output logic                    SUpdate,
   output logic                    SIn,
   input  logic                    SOut
`ifdef SCAN_DRIVER_ABORT_EN
   ,
   input  logic                    Abort,
   output logic                    Aborted
`endif
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BW = (CHAIN_LENGTH > 1) ? $clog2(CHAIN_LENGTH) : 1;

   typedef enum logic [3:0] {
      IDLE, CAP_S, CAP_P, CAP_G, CAP_N, SH_S, SH_P, SH_G, SH_N, TAIL, UPD, DONE
   } state_t;

   state_t                  state, nxt;
   logic [PW-1:0]           ph;
   logic [BW-1:0]           bitcnt;
   logic [CHAIN_LENGTH-1:0] sr, sr_d;
   logic                    sout_q;
   logic                    upd_en;
   logic                    last_ph, last_bit, abort_req;

   // NOTE: every signal written here gets a default first, so no latch can be inferred.
   always_comb begin
      last_ph   = (ph == PW'(CLK_DIV - 1));
      last_bit  = (bitcnt == BW'(CHAIN_LENGTH - 1));
      abort_req = 1'b0;
`ifdef SCAN_DRIVER_ABORT_EN
      abort_req = Abort && (state != IDLE) && (state != DONE);
`endif
      nxt = state;
      case (state)
         IDLE:    if (Start)   nxt = CaptureEn ? CAP_S : SH_S;
         CAP_S:   if (last_ph) nxt = CAP_P;
         CAP_P:   if (last_ph) nxt = CAP_G;
         CAP_G:   if (last_ph) nxt = CAP_N;
         CAP_N:   if (last_ph) nxt = SH_S;
         SH_S:    if (last_ph) nxt = SH_P;
         SH_P:    if (last_ph) nxt = SH_G;
         SH_G:    if (last_ph) nxt = SH_N;
         SH_N:    if (last_ph) nxt = last_bit ? TAIL : SH_S;
         TAIL:    if (last_ph) nxt = upd_en ? UPD : DONE;
         UPD:     if (last_ph) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (abort_req) nxt = DONE;

      // One register serves both directions: write bits leave at the MSB while read bits enter at the LSB.
      sr_d = sr;
      if (state == IDLE && Start)
         sr_d = WrData;
      else if (state == SH_N && last_ph && !abort_req)
         sr_d = (sr << 1) | CHAIN_LENGTH'(sout_q);
   end

   // NOTE: all state and outputs update with non-blocking assignments; outputs are decoded from nxt
   // so they are registered yet line up with the state they belong to.
   always_ff @(posedge Clk) begin
      SReset <= Reset;
      if (Reset) begin
         state   <= IDLE;
         ph      <= '0;
         bitcnt  <= '0;
         sr      <= '0;
         sout_q  <= 1'b0;
         upd_en  <= 1'b0;
         RdData  <= '0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
         SClkP   <= 1'b0;
         SClkN   <= 1'b0;
         SEnable <= 1'b0;
         SUpdate <= 1'b0;
         SIn     <= 1'b0;
`ifdef SCAN_DRIVER_ABORT_EN
         Aborted <= 1'b0;
`endif
      end else begin
         state <= nxt;
         ph    <= (nxt != state) ? '0 : ph + PW'(1);
         sr    <= sr_d;

         if (state == IDLE && Start) begin
            upd_en <= UpdateEn;
            bitcnt <= '0;
         end else if (state == SH_N && last_ph && !abort_req) begin
            bitcnt <= bitcnt + BW'(1);
         end

         if (state == SH_S && last_ph) sout_q <= SOut;

         // An aborted pass leaves the previous read vector in place.
         if (nxt == DONE && state != DONE && !abort_req) RdData <= sr;

`ifdef SCAN_DRIVER_ABORT_EN
         if (state == IDLE && Start) Aborted <= 1'b0;
         else if (abort_req)         Aborted <= 1'b1;
`endif

         Busy    <= (nxt != IDLE);
         Done    <= (nxt == DONE);
         SClkP   <= (nxt inside {CAP_P, SH_P});
         SClkN   <= (nxt inside {CAP_N, SH_N});
         SEnable <= (nxt inside {SH_S, SH_P, SH_G, SH_N});
         SUpdate <= (nxt == UPD);
         // SIn is held for the whole bit slot so it is stable around both clock phases.
         SIn     <= (nxt inside {SH_S, SH_P, SH_G, SH_N}) && sr_d[CHAIN_LENGTH-1];
      end
   end

endmodule

// File: tb/tb_scan_chain_driver.sv
// Directed bench for scan_chain_driver: an 87-bit / CLK_DIV=2 instance and a 1-bit / CLK_DIV=1
// instance, each driving a two-phase pass-through chain model with a parallel capture input.
module tb_scan_chain_driver;
   localparam int L = 87;
   localparam int D = 2;

   logic         clk, reset;
   logic         start, capture_en, update_en, sout;
   logic [L-1:0] wr_data, rd_data;
   logic         busy, done, sclkp, sclkn, sreset, senable, supdate, sin;

   logic         s_start, s_cap, s_upd, s_sout;
   logic [0:0]   s_wr, s_rd;
   logic         s_busy, s_done, s_sclkp, s_sclkn, s_sreset, s_senable, s_supdate, s_sin;
`ifdef SCAN_DRIVER_ABORT_EN
   logic         abort, aborted, s_aborted;
`endif

   int vectors = 0;
   int miscompares = 0;

   logic [L-1:0] chain = '0;
   logic [L-1:0] latch = '0;
   logic         s_chain = 1'b0;
   logic         s_latch = 1'b0;
   logic         s_capbit = 1'b0;
   logic [L-1:0] alt = 87'h55_5555_5555_5555_5555_5555;
   logic [L-1:0] r2 = 87'h7B_3C1F_9A27_E480_B6D3_0F5C;
   logic [L-1:0] cap_pattern = 87'h5A_5A5A_5A5A_5A5A_5A5A_5A5A;

   int   st_busy, st_prise, st_pbad, st_upd, st_first_upd, st_last_n, st_done;
   bit   st_rd_moved, st_overlap, st_timeout;
   logic st_first_p_sen;
   int   st_s_busy, st_s_done, st_s_upd;

   scan_chain_driver #(.CHAIN_LENGTH(L), .CLK_DIV(D)) u_big (
      .Clk(clk), .Reset(reset), .Start(start), .CaptureEn(capture_en), .UpdateEn(update_en),
      .WrData(wr_data), .RdData(rd_data), .Busy(busy), .Done(done), .SClkP(sclkp), .SClkN(sclkn),
      .SReset(sreset), .SEnable(senable), .SUpdate(supdate), .SIn(sin), .SOut(sout)
`ifdef SCAN_DRIVER_ABORT_EN
      , .Abort(abort), .Aborted(aborted)
`endif
   );

   scan_chain_driver #(.CHAIN_LENGTH(1), .CLK_DIV(1)) u_small (
      .Clk(clk), .Reset(reset), .Start(s_start), .CaptureEn(s_cap), .UpdateEn(s_upd),
      .WrData(s_wr), .RdData(s_rd), .Busy(s_busy), .Done(s_done), .SClkP(s_sclkp), .SClkN(s_sclkn),
      .SReset(s_sreset), .SEnable(s_senable), .SUpdate(s_supdate), .SIn(s_sin), .SOut(s_sout)
`ifdef SCAN_DRIVER_ABORT_EN
      , .Abort(1'b0), .Aborted(s_aborted)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Two-phase chain: SClkP loads the master latch (shift or parallel capture), SClkN moves it to the slaves.
   assign sout   = chain[L-1];
   assign s_sout = s_chain;
   always @(posedge sclkp)   latch   <= senable ? {chain[L-2:0], sin} : cap_pattern;
   always @(posedge sclkn)   chain   <= latch;
   always @(posedge s_sclkp) s_latch <= s_senable ? s_sin : s_capbit;
   always @(posedge s_sclkn) s_chain <= s_latch;

   always @(negedge clk) begin
      if (!reset) assert (!(sclkp && sclkn) && !(s_sclkp && s_sclkn)) else $error("scan clocks overlap");
   end

   task automatic run_big(input logic [L-1:0] wr, input logic cap, input logic upd, input bit poke);
      logic         prev_p = 1'b0;
      int           p_run = 0;
      logic [L-1:0] rd_before;
      st_busy = 0; st_prise = 0; st_pbad = 0; st_upd = 0; st_first_upd = -1; st_last_n = -1;
      st_done = 0; st_rd_moved = 0; st_overlap = 0; st_timeout = 1; st_first_p_sen = 1'bx;
      @(negedge clk);
      wr_data = wr; capture_en = cap; update_en = upd; start = 1'b1;
      rd_before = rd_data;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         start = poke && busy;
         if (busy) st_busy++;
         if (sclkp && !prev_p) begin
            if (st_prise == 0) st_first_p_sen = senable;
            st_prise++;
         end
         if (sclkp) p_run++;
         else if (p_run != 0) begin
            if (p_run != D) st_pbad++;
            p_run = 0;
         end
         prev_p = sclkp;
         if (sclkn) st_last_n = cyc;
         if (supdate) begin
            st_upd++;
            if (st_first_upd < 0) st_first_upd = cyc;
         end
         if (done) st_done++;
         if (busy && !done && rd_data !== rd_before) st_rd_moved = 1;
         if (sclkp && sclkn) st_overlap = 1;
         if (!busy) begin
            st_timeout = 0;
            break;
         end
      end
      start = 1'b0;
      vectors++;
      if (st_timeout) begin miscompares++; $display("FAIL op_timeout: busy still %b after 4000 cycles, want 0", busy); end
   endtask

   task automatic run_small(input logic wr, input logic cap, input logic upd);
      st_s_busy = 0; st_s_done = 0; st_s_upd = 0;
      @(negedge clk);
      s_wr = wr; s_cap = cap; s_upd = upd; s_start = 1'b1;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge clk);
         s_start = 1'b0;
         if (s_busy) st_s_busy++;
         if (s_done) st_s_done++;
         if (s_supdate) st_s_upd++;
         if (!s_busy) break;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if ({busy, done, sclkp, sclkn, senable, supdate, sin} !== 7'b0) begin
         miscompares++; $display("FAIL rst_outputs: got %b want 0000000", {busy, done, sclkp, sclkn, senable, supdate, sin});
      end
      vectors++; if (sreset !== 1'b1) begin miscompares++; $display("FAIL rst_sreset: got %b want 1", sreset); end
      vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL rst_rddata: got %h want 0", rd_data); end
      vectors++; if (s_busy !== 1'b0 || s_rd !== 1'b0) begin miscompares++; $display("FAIL rst_small: busy %b rd %b want 0 0", s_busy, s_rd); end
      reset = 1'b0;
      @(negedge clk);
      vectors++; if (sreset !== 1'b0) begin miscompares++; $display("FAIL rst_sreset_fall: got %b want 0", sreset); end
   endtask

   task automatic test_shift_alt();
      run_big(alt, 1'b0, 1'b1, 1'b0);
      vectors++; if (st_busy !== 701) begin miscompares++; $display("FAIL alt_busy: got %0d want 701", st_busy); end
      vectors++; if (st_prise !== 87) begin miscompares++; $display("FAIL alt_pclk_count: got %0d want 87", st_prise); end
      vectors++; if (st_pbad !== 0) begin miscompares++; $display("FAIL alt_pclk_width: %0d pulses not %0d wide", st_pbad, D); end
      vectors++; if (st_upd !== 2) begin miscompares++; $display("FAIL alt_update_len: got %0d want 2", st_upd); end
      vectors++; if (st_first_upd - st_last_n !== 3) begin miscompares++; $display("FAIL alt_update_pos: got %0d want 3", st_first_upd - st_last_n); end
      vectors++; if (st_done !== 1) begin miscompares++; $display("FAIL alt_done: got %0d want 1", st_done); end
      vectors++; if (st_rd_moved !== 1'b0) begin miscompares++; $display("FAIL alt_rd_early: got %b want 0", st_rd_moved); end
      vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL alt_rddata: got %h want 0", rd_data); end
      vectors++; if (chain !== alt) begin miscompares++; $display("FAIL alt_chain: got %h want %h", chain, alt); end
   endtask

   task automatic test_shift_random();
      run_big(r2, 1'b0, 1'b1, 1'b0);
      vectors++; if (st_busy !== 701) begin miscompares++; $display("FAIL r2_busy: got %0d want 701", st_busy); end
      vectors++; if (rd_data !== alt) begin miscompares++; $display("FAIL r2_rddata: got %h want %h", rd_data, alt); end
      vectors++; if (chain !== r2) begin miscompares++; $display("FAIL r2_chain: got %h want %h", chain, r2); end
      vectors++; if (st_done !== 1 || st_overlap !== 1'b0) begin miscompares++; $display("FAIL r2_done_overlap: got %0d/%b want 1/0", st_done, st_overlap); end
   endtask

   task automatic test_reset_mid();
      bit stray = 0;
      @(negedge clk);
      wr_data = r2; capture_en = 1'b0; update_en = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (150) @(negedge clk);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b want 1", busy); end
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if ({busy, done, sclkp, sclkn, senable, supdate, sin} !== 7'b0) begin
         miscompares++; $display("FAIL mid_outputs: got %b want 0000000", {busy, done, sclkp, sclkn, senable, supdate, sin});
      end
      vectors++; if (sreset !== 1'b1) begin miscompares++; $display("FAIL mid_sreset: got %b want 1", sreset); end
      vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL mid_rddata: got %h want 0", rd_data); end
      repeat (2) @(negedge clk) if (done || supdate) stray = 1;
      reset = 1'b0;
      @(negedge clk);
      vectors++; if (sreset !== 1'b0) begin miscompares++; $display("FAIL mid_sreset_fall: got %b want 0", sreset); end
      repeat (5) @(negedge clk) if (done || busy || supdate) stray = 1;
      vectors++; if (stray !== 1'b0) begin miscompares++; $display("FAIL mid_no_done: got %b want 0", stray); end
   endtask

   task automatic test_capture();
      run_big(alt, 1'b1, 1'b1, 1'b0);
      vectors++; if (st_busy !== 709) begin miscompares++; $display("FAIL cap_busy: got %0d want 709", st_busy); end
      vectors++; if (st_prise !== 88) begin miscompares++; $display("FAIL cap_pclk_count: got %0d want 88", st_prise); end
      vectors++; if (st_first_p_sen !== 1'b0) begin miscompares++; $display("FAIL cap_senable: got %b want 0", st_first_p_sen); end
      vectors++; if (rd_data !== cap_pattern) begin miscompares++; $display("FAIL cap_rddata: got %h want %h", rd_data, cap_pattern); end
      vectors++; if (chain !== alt) begin miscompares++; $display("FAIL cap_chain: got %h want %h", chain, alt); end
   endtask

   task automatic test_start_ignored();
      bit restarted = 0;
      run_big(r2, 1'b0, 1'b0, 1'b1);
      vectors++; if (st_busy !== 699) begin miscompares++; $display("FAIL ign_busy: got %0d want 699", st_busy); end
      vectors++; if (st_done !== 1) begin miscompares++; $display("FAIL ign_done: got %0d want 1", st_done); end
      vectors++; if (st_upd !== 0) begin miscompares++; $display("FAIL ign_update: got %0d want 0", st_upd); end
      vectors++; if (rd_data !== alt) begin miscompares++; $display("FAIL ign_rddata: got %h want %h", rd_data, alt); end
      repeat (5) @(negedge clk) if (busy) restarted = 1;
      vectors++; if (restarted !== 1'b0) begin miscompares++; $display("FAIL ign_restart: got %b want 0", restarted); end
   endtask

   task automatic test_small();
      s_capbit = 1'b0;
      run_small(1'b1, 1'b0, 1'b1);
      vectors++; if (st_s_busy !== 7) begin miscompares++; $display("FAIL small_busy_upd: got %0d want 7", st_s_busy); end
      vectors++; if (st_s_done !== 1 || st_s_upd !== 1) begin miscompares++; $display("FAIL small_done_upd: got %0d/%0d want 1/1", st_s_done, st_s_upd); end
      vectors++; if (s_rd !== 1'b0 || s_chain !== 1'b1) begin miscompares++; $display("FAIL small_op1: rd %b chain %b want 0 1", s_rd, s_chain); end
      run_small(1'b1, 1'b1, 1'b0);
      vectors++; if (st_s_busy !== 10) begin miscompares++; $display("FAIL small_busy_cap: got %0d want 10", st_s_busy); end
      vectors++; if (s_rd !== 1'b0 || s_chain !== 1'b1) begin miscompares++; $display("FAIL small_op2: rd %b chain %b want 0 1", s_rd, s_chain); end
      run_small(1'b0, 1'b0, 1'b0);
      vectors++; if (st_s_busy !== 6) begin miscompares++; $display("FAIL small_busy_plain: got %0d want 6", st_s_busy); end
      vectors++; if (s_rd !== 1'b1 || s_chain !== 1'b0) begin miscompares++; $display("FAIL small_op3: rd %b chain %b want 1 0", s_rd, s_chain); end
   endtask

`ifdef SCAN_DRIVER_ABORT_EN
   task automatic test_abort();
      int           rises = 0;
      logic         prev_p = 1'b0;
      logic [L-1:0] rd_before;
      rd_before = rd_data;
      @(negedge clk);
      wr_data = alt; capture_en = 1'b0; update_en = 1'b1; start = 1'b1;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         if (sclkp && !prev_p) rises++;
         prev_p = sclkp;
         if (rises == 41) break;
      end
      vectors++; if (rises !== 41) begin miscompares++; $display("FAIL abort_reach_bit40: got %0d pulses want 41", rises); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vectors++;
      if ({sclkp, sclkn, senable, supdate} !== 4'b0) begin
         miscompares++; $display("FAIL abort_outputs: got %b want 0000", {sclkp, sclkn, senable, supdate});
      end
      vectors++; if (done !== 1'b1 || aborted !== 1'b1) begin miscompares++; $display("FAIL abort_done: done %b aborted %b want 1 1", done, aborted); end
      vectors++; if (rd_data !== rd_before) begin miscompares++; $display("FAIL abort_rddata: got %h want %h", rd_data, rd_before); end
      @(negedge clk);
      vectors++; if (done !== 1'b0 || busy !== 1'b0 || aborted !== 1'b1 || supdate !== 1'b0) begin
         miscompares++; $display("FAIL abort_after: done %b busy %b aborted %b supdate %b want 0 0 1 0", done, busy, aborted, supdate);
      end
      run_big(alt, 1'b0, 1'b0, 1'b0);
      vectors++; if (aborted !== 1'b0 || st_done !== 1) begin miscompares++; $display("FAIL abort_clear: aborted %b done %0d want 0 1", aborted, st_done); end
   endtask
`endif

   initial begin
      reset = 1'b1; start = 1'b0; capture_en = 1'b0; update_en = 1'b0; wr_data = '0;
      s_start = 1'b0; s_cap = 1'b0; s_upd = 1'b0; s_wr = 1'b0;
`ifdef SCAN_DRIVER_ABORT_EN
      abort = 1'b0;
`endif
      test_reset();
      test_shift_alt();
      test_shift_random();
      test_reset_mid();
      test_capture();
      test_start_ignored();
      test_small();
`ifdef SCAN_DRIVER_ABORT_EN
      test_abort();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
